ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single RAMHelper port between the instruction-fetch requester and the load/store requester. This replaces the combinational priority mux in the top level with a sequenced, handshaked arbiter.
- Issues at most one RAM access per cycle and returns the response one cycle later, matching the RAMHelper registered read.
- Uses fixed data-over-fetch priority, with a starvation guard that guarantees fetch forward progress.

Parameters:
- ADDR_W, 64, request/RAM address width
- DATA_W, 64, RAM data/mask width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets priority (1..15)

Ports:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch byte address (pc)
- if_flush  in  1  discard pending fetch response (redirect)
- if_resp_valid  out  1  fetch response valid
- if_resp_inst  out  32  fetched instruction
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1=store, 0=load
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_wmask  in  DATA_W  store bit mask
- d_resp_valid  out  1  data response (load data or store ack)
- d_resp_rdata  out  DATA_W  load data (0 for store ack)
- ram_ren  out  1  RAMHelper read enable
- ram_ridx  out  ADDR_W  RAMHelper read index
- ram_rdata  in  DATA_W  RAMHelper read data, valid one cycle after ram_ren
- ram_wen  out  1  RAMHelper write enable
- ram_widx  out  ADDR_W  RAMHelper write index
- ram_wdata  out  DATA_W  RAMHelper write data
- ram_wmask  out  DATA_W  RAMHelper write mask

Behaviour:
- Reset: all of the following are cleared asynchronously on reset_n low.
  - state=IDLE, starve_cnt=0, sel_hi=0.
  - if_resp_valid=0, d_resp_valid=0, if_req_ready=0, d_req_ready=0, ram_ren=0, ram_wen=0.
  - Response data outputs=0.
  - A pending response is dropped and never presented.
- Grant (combinational, every cycle, every state):
  - Data wins if d_req_valid, unless starve_cnt==STARVE_MAX and if_req_valid, in which case fetch wins.
  - Fetch wins if if_req_valid and data does not win.
  - Only the winner sees ready=1. A request is accepted when valid&&ready; requesters hold their request stable until accepted.
- RAM drive (same cycle as the grant):
  - Fetch grant: ram_ren=1, ram_ridx=if_req_addr.
  - Data load: ram_ren=1, ram_ridx=d_req_addr.
  - Data store: ram_wen=1, ram_widx/wdata/wmask from the d_req inputs, ram_ren=0.
  - No grant: ren=wen=0, index outputs 0.
  - Addresses are forwarded unchanged.
- States:
  - IDLE: no response pending.
  - RESP_IF: fetch read issued last cycle.
  - RESP_LD: load issued last cycle.
  - RESP_ST: store issued last cycle.
  - Next state is set by this cycle's grant (RESP_IF/RESP_LD/RESP_ST), else IDLE. Back-to-back grants every cycle are allowed.
- Responses (combinational from state and ram_rdata, one-cycle latency, no backpressure):
  - RESP_IF: if_resp_valid=!if_flush; if_resp_inst = sel_hi ? ram_rdata[63:32] : ram_rdata[31:0]. sel_hi is if_req_addr[2], registered at the fetch grant.
  - RESP_LD: d_resp_valid=1, d_resp_rdata=ram_rdata.
  - RESP_ST: d_resp_valid=1, d_resp_rdata=0.
  - if_flush outside RESP_IF has no effect. It does not block a new fetch grant in the same cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when if_req_valid && !fetch granted.
  - Clears on a fetch grant or when if_req_valid=0.
- Boundary conditions:
  - A store with wmask=0 still issues ram_wen and is acked.
  - Both requesters idle: no RAM activity and state returns to IDLE.
  - Any address, including below 0x8000_0000, is forwarded (skip handling belongs to difftest, not here).

Decomposition:
- Shared defines (defines.v): ADDR_BUS and DATA_BUS, plus state encodings ARB_IDLE/ARB_RESP_IF/ARB_RESP_LD/ARB_RESP_ST (2-bit).
- One natural sub-module, arb_starve_cnt: saturating counter with inc/clr inputs and a sat output.
- The top level instantiates ram_port_arbiter between rvcpu and RAMHelper, replacing the inst/ReadAddr muxes.

Test Plan:
- Fetch only, addr 0x8000_0004, ram_rdata 0x1111_2222_3333_4444 -> ready in T; if_resp_valid in T+1 with inst 0x1111_2222.
- Simultaneous if_req (0x8000_0000) and d_req load (0x8000_1000) -> d granted T, d_resp_valid T+1; fetch granted T+1, if_resp_valid T+2 with inst = low word.
- d_req_valid held high 6 cycles with fetch pending, STARVE_MAX=4 -> fetch denied 4 cycles, granted in cycle 5; starve_cnt returns to 0.
- Store: addr 0x8000_0010, wdata 0xDEAD_BEEF, mask 0xFFFF_FFFF -> ram_wen=1 with those values in T, ram_ren=0; d_resp_valid=1, rdata=0 in T+1.
- Fetch granted T, if_flush=1 in T+1 -> if_resp_valid stays 0; a new fetch is granted in T+1 and responds in T+2.
- reset_n low in RESP_LD -> d_resp_valid drops immediately, state IDLE; after release, the first request responds normally.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and constants for the RAM port arbiter
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_RESP_IF = 2'd1,
        ARB_RESP_LD = 2'd2,
        ARB_RESP_ST = 2'd3
    } arb_state_t;

    localparam int STARVE_CNT_W = 4;
    localparam int INST_W       = 32;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of consecutive denied fetch cycles
module arb_starve_cnt
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STARVE_CNT_W-1:0] MAX_L = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_L)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == MAX_L);

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - data-over-fetch arbiter for the single RAMHelper port
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [INST_W-1:0] if_resp_inst,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [DATA_W-1:0] d_req_wmask,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_rdata,

    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_ridx,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_widx,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask
);

    arb_state_t state, state_nxt;
    logic       sel_hi;
    logic       starve_sat;
    logic       if_grant;
    logic       d_grant;

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (if_req_valid && !if_grant),
        .clr     (if_grant || !if_req_valid),
        .sat     (starve_sat)
    );

    // Grants are gated by reset so no handshake or RAM access leaks out while held in reset.
    always_comb begin
        if_grant = 1'b0;
        d_grant  = 1'b0;
        if (reset_n) begin
            if (d_req_valid && !(starve_sat && if_req_valid)) begin
                d_grant = 1'b1;
            end else if (if_req_valid) begin
                if_grant = 1'b1;
            end
        end
    end

    assign if_req_ready = if_grant;
    assign d_req_ready  = d_grant;

    always_comb begin
        ram_ren   = 1'b0;
        ram_ridx  = '0;
        ram_wen   = 1'b0;
        ram_widx  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        if (if_grant) begin
            ram_ren  = 1'b1;
            ram_ridx = if_req_addr;
        end else if (d_grant && !d_req_we) begin
            ram_ren  = 1'b1;
            ram_ridx = d_req_addr;
        end else if (d_grant) begin
            ram_wen   = 1'b1;
            ram_widx  = d_req_addr;
            ram_wdata = d_req_wdata;
            ram_wmask = d_req_wmask;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            sel_hi <= 1'b0;
        end else begin
            state <= state_nxt;
            if (if_grant) begin
                sel_hi <= if_req_addr[2];
            end
        end
    end

    always_comb begin
        state_nxt = ARB_IDLE;
        if (if_grant) begin
            state_nxt = ARB_RESP_IF;
        end else if (d_grant) begin
            state_nxt = d_req_we ? ARB_RESP_ST : ARB_RESP_LD;
        end
    end

    // RAMHelper read data arrives one cycle after ren, so responses decode straight from state.
    always_comb begin
        if_resp_valid = 1'b0;
        if_resp_inst  = '0;
        d_resp_valid  = 1'b0;
        d_resp_rdata  = '0;
        case (state)
            ARB_RESP_IF: begin
                if_resp_valid = !if_flush;
                if_resp_inst  = sel_hi ? ram_rdata[2*INST_W-1:INST_W] : ram_rdata[INST_W-1:0];
            end
            ARB_RESP_LD: begin
                d_resp_valid = 1'b1;
                d_resp_rdata = ram_rdata;
            end
            ARB_RESP_ST: begin
                d_resp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_req_addr;
    logic        if_flush;
    logic        if_resp_valid;
    logic [31:0] if_resp_inst;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [63:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic [63:0] d_req_wmask;
    logic        d_resp_valid;
    logic [63:0] d_resp_rdata;
    logic        ram_ren;
    logic [63:0] ram_ridx;
    logic [63:0] ram_rdata;
    logic        ram_wen;
    logic [63:0] ram_widx;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;

    int total = 0;
    int bad   = 0;

    ram_port_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_flush      (if_flush),
        .if_resp_valid (if_resp_valid),
        .if_resp_inst  (if_resp_inst),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_we      (d_req_we),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_wmask   (d_req_wmask),
        .d_resp_valid  (d_resp_valid),
        .d_resp_rdata  (d_resp_rdata),
        .ram_ren       (ram_ren),
        .ram_ridx      (ram_ridx),
        .ram_rdata     (ram_rdata),
        .ram_wen       (ram_wen),
        .ram_widx      (ram_widx),
        .ram_wdata     (ram_wdata),
        .ram_wmask     (ram_wmask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0000;
        if_flush     = 1'b0;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_req_addr   = 64'h8000_1000;
        d_req_wdata  = '0;
        d_req_wmask  = '0;
        ram_rdata    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("rst_if_ready", if_req_ready, 0);
        check("rst_d_ready", d_req_ready, 0);
        check("rst_ren", ram_ren, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_if_resp", if_resp_valid, 0);
        check("rst_d_resp", d_resp_valid, 0);
        check("rst_d_rdata", d_resp_rdata, 0);
        repeat (2) @(posedge clock);
        #1;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        reset_n      = 1'b1;
        #1;
        check("idle_ren", ram_ren, 0);
        check("idle_ridx", ram_ridx, 0);

        // fetch only, upper word
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0004;
        #1;
        check("f1_ready", if_req_ready, 1);
        check("f1_ren", ram_ren, 1);
        check("f1_ridx", ram_ridx, 64'h8000_0004);
        check("f1_wen", ram_wen, 0);
        step();
        if_req_valid = 1'b0;
        ram_rdata    = 64'h1111_2222_3333_4444;
        #1;
        check("f1_resp_valid", if_resp_valid, 1);
        check("f1_inst", if_resp_inst, 64'h1111_2222);
        check("f1_d_resp", d_resp_valid, 0);
        check("f1_ren_after", ram_ren, 0);
        step();
        check("f1_idle_resp", if_resp_valid, 0);
        check("f1_idle_state", dut.state, 0);

        // simultaneous fetch and load: data first
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0000;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_req_addr   = 64'h8000_1000;
        #1;
        check("s_d_ready", d_req_ready, 1);
        check("s_if_ready0", if_req_ready, 0);
        check("s_ridx_d", ram_ridx, 64'h8000_1000);
        step();
        d_req_valid = 1'b0;
        ram_rdata   = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        check("s_d_resp", d_resp_valid, 1);
        check("s_d_rdata", d_resp_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        check("s_if_ready1", if_req_ready, 1);
        check("s_ridx_if", ram_ridx, 64'h8000_0000);
        step();
        if_req_valid = 1'b0;
        ram_rdata    = 64'h5555_6666_7777_8888;
        #1;
        check("s_if_resp", if_resp_valid, 1);
        check("s_if_inst", if_resp_inst, 64'h7777_8888);
        check("s_d_resp_off", d_resp_valid, 0);
        step();

        // starvation guard with STARVE_MAX=4
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0008;
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_req_addr   = 64'h8000_2000;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("stv_d_ready%0d", i), d_req_ready, 1);
            check($sformatf("stv_if_deny%0d", i), if_req_ready, 0);
            step();
        end
        check("stv_cnt_sat", dut.u_starve.cnt, 4);
        #1;
        check("stv_if_grant", if_req_ready, 1);
        check("stv_d_wait", d_req_ready, 0);
        check("stv_ridx", ram_ridx, 64'h8000_0008);
        step();
        if_req_valid = 1'b0;
        ram_rdata    = 64'h0102_0304_0506_0708;
        #1;
        check("stv_cnt_clr", dut.u_starve.cnt, 0);
        check("stv_if_resp", if_resp_valid, 1);
        check("stv_if_inst", if_resp_inst, 64'h0506_0708);
        check("stv_d_ready6", d_req_ready, 1);
        step();
        d_req_valid = 1'b0;
        step();

        // store, full mask
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 64'h8000_0010;
        d_req_wdata = 64'hDEAD_BEEF;
        d_req_wmask = 64'hFFFF_FFFF;
        #1;
        check("st_ready", d_req_ready, 1);
        check("st_wen", ram_wen, 1);
        check("st_ren", ram_ren, 0);
        check("st_widx", ram_widx, 64'h8000_0010);
        check("st_wdata", ram_wdata, 64'hDEAD_BEEF);
        check("st_wmask", ram_wmask, 64'hFFFF_FFFF);
        step();
        // store with empty mask to a low address
        d_req_addr  = 64'h10;
        d_req_wmask = 64'h0;
        ram_rdata   = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("st_resp", d_resp_valid, 1);
        check("st_rdata0", d_resp_rdata, 0);
        check("st0_wen", ram_wen, 1);
        check("st0_widx", ram_widx, 64'h10);
        check("st0_wmask", ram_wmask, 0);
        step();
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        #1;
        check("st0_resp", d_resp_valid, 1);
        check("st0_rdata", d_resp_rdata, 0);
        step();

        // flush of a pending fetch response, new fetch granted in the same cycle
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0024;
        #1;
        check("fl_ready0", if_req_ready, 1);
        step();
        if_req_addr = 64'h8000_0040;
        if_flush    = 1'b1;
        ram_rdata   = 64'hEEEE_EEEE_EEEE_EEEE;
        #1;
        check("fl_resp_blocked", if_resp_valid, 0);
        check("fl_ready1", if_req_ready, 1);
        check("fl_ridx1", ram_ridx, 64'h8000_0040);
        step();
        if_flush     = 1'b0;
        if_req_valid = 1'b0;
        ram_rdata    = 64'h9999_AAAA_BBBB_CCCC;
        #1;
        check("fl_resp2", if_resp_valid, 1);
        check("fl_inst2", if_resp_inst, 64'hBBBB_CCCC);
        step();

        // reset while a load response is pending
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_addr  = 64'h8000_3000;
        #1;
        check("rl_ready", d_req_ready, 1);
        step();
        d_req_valid = 1'b0;
        ram_rdata   = 64'h0BAD_F00D_0BAD_F00D;
        #1;
        check("rl_resp_pre", d_resp_valid, 1);
        reset_n = 1'b0;
        #1;
        check("rl_resp_drop", d_resp_valid, 0);
        check("rl_rdata_drop", d_resp_rdata, 0);
        check("rl_state", dut.state, 0);
        step();
        reset_n = 1'b1;
        #1;
        check("rl_after_rel", d_resp_valid, 0);
        if_req_valid = 1'b1;
        if_req_addr  = 64'h8000_0004;
        #1;
        check("rl_f_ready", if_req_ready, 1);
        step();
        if_req_valid = 1'b0;
        ram_rdata    = 64'hCAFE_0001_CAFE_0002;
        #1;
        check("rl_f_resp", if_resp_valid, 1);
        check("rl_f_inst", if_resp_inst, 64'hCAFE_0001);
        step();
        check("end_idle", if_resp_valid | d_resp_valid | ram_ren | ram_wen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
